button_event_decoder: RTL and testbench
=======================================

BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 SHALL have parameter BUTTON_COUNT, default 5: number of independent debounced button channels.
REQ-002 SHALL have parameter COUNTER_WIDTH, default 24: width of hold/repeat counters and threshold inputs.
REQ-003 SHALL have port i_clock, input, 1: single clock; all logic is rising-edge on it.
REQ-004 SHALL have port i_reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port i_buttons, input, BUTTON_COUNT: debounced, clock-synchronous button levels; 1 = pressed.
REQ-006 SHALL have port i_long_press_count, input, COUNTER_WIDTH: hold cycles to long-press; 0 disables long-press.
REQ-007 SHALL have port i_repeat_count, input, COUNTER_WIDTH: cycles between auto-repeat pulses; 0 disables repeat.
REQ-008 SHALL have port o_press_pulse, output, BUTTON_COUNT: one-cycle pulse per press.
REQ-009 SHALL have port o_release_pulse, output, BUTTON_COUNT: one-cycle pulse per release.
REQ-010 SHALL have port o_long_press_pulse, output, BUTTON_COUNT: one-cycle pulse at long-press threshold.
REQ-011 SHALL have port o_repeat_pulse, output, BUTTON_COUNT: one-cycle auto-repeat pulse.
REQ-012 SHALL have port o_held, output, BUTTON_COUNT: level, 1 while a channel is not IDLE.

Function
REQ-013 SHALL give each channel its own FSM {IDLE, PRESSED, LONG}, hold counter and repeat counter; channels SHALL be fully independent.
REQ-014 SHALL register all outputs; each output bit SHALL depend only on its own channel.
REQ-015 IDLE, i_buttons[n]=1 at edge -> PRESSED, hold counter=1, o_press_pulse[n]=1 for the next cycle (latency 1 clock).
REQ-016 PRESSED, button held: hold counter increments by 1 per cycle, saturating at all-ones (no wrap).
REQ-017 PRESSED, button held, i_long_press_count!=0, hold counter >= i_long_press_count -> LONG, o_long_press_pulse[n]=1 for one cycle, repeat counter=1.
REQ-018 Thresholds SHALL be sampled live each cycle; lowering below current count fires on the next edge.
REQ-019 LONG, button held, i_repeat_count!=0: repeat counter increments; when >= i_repeat_count, o_repeat_pulse[n]=1 for one cycle and repeat counter reloads to 1.
REQ-020 PRESSED or LONG, i_buttons[n]=0 at edge -> IDLE, counters cleared, o_release_pulse[n]=1 for one cycle.
REQ-021 Release on the same edge as a long-press or repeat threshold hit: release wins; no long/repeat pulse.
REQ-022 At most one of press/release/long/repeat pulse SHALL be 1 per channel per cycle.
REQ-023 o_held[n] SHALL be 1 in the cycle carrying the press pulse through the cycle before the release pulse.
REQ-024 A one-cycle input high SHALL yield a press pulse followed directly by a release pulse.

Reset
REQ-025 i_reset_n=0 SHALL asynchronously force all FSMs to IDLE, all counters to 0, all outputs to 0.
REQ-026 After reset release, a button already high SHALL produce a press pulse on the first active edge (normal IDLE path).
REQ-027 Reset asserted mid-hold SHALL emit no release pulse; outputs go 0 immediately.

Configuration
REQ-028 Macro BUTTON_EVENT_AUTO_REPEAT_EN: defined -> REQ-019 repeat logic compiled in.
REQ-029 Not defined -> repeat counters absent, o_repeat_pulse tied to 0, i_repeat_count ignored; all other behaviour unchanged.

Verification
REQ-030 Reset, i_buttons=0 -> all outputs 0; assert i_reset_n=0 mid-hold -> outputs 0 same cycle, no release pulse.
REQ-031 Long=10, btn0 held 5 cycles -> press pulse cycle 1, release pulse cycle 6, no long pulse, o_held=1 cycles 1-5.
REQ-032 Long=10, repeat=4 (macro on), btn2 held 30 cycles -> press@1, long@10, repeats @14,18,22,26,30 suppressed by release? held exactly through; release pulse after drop; macro off -> no repeats.
REQ-033 Long=0, btn1 held 100 cycles -> press pulse only, no long/repeat, release on drop.
REQ-034 Long=8, btn3 release aligned with count 8 edge -> release pulse only, no long pulse.
REQ-035 All 5 buttons pressed together, staggered releases -> 5 simultaneous press pulses, independent release pulses.

Source files
------------

// File: rtl/button_event_decoder.sv
// Per-channel button event decoder: press/release/long-press/auto-repeat pulses plus a held level.
// Auto-repeat is compiled in only when BUTTON_EVENT_AUTO_REPEAT_EN is defined.
module button_event_decoder #(
    parameter int unsigned BUTTON_COUNT  = 5,
    parameter int unsigned COUNTER_WIDTH = 24
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    input  logic [BUTTON_COUNT-1:0]  i_buttons,
    input  logic [COUNTER_WIDTH-1:0] i_long_press_count,
    input  logic [COUNTER_WIDTH-1:0] i_repeat_count,
    output logic [BUTTON_COUNT-1:0]  o_press_pulse,
    output logic [BUTTON_COUNT-1:0]  o_release_pulse,
    output logic [BUTTON_COUNT-1:0]  o_long_press_pulse,
    output logic [BUTTON_COUNT-1:0]  o_repeat_pulse,
    output logic [BUTTON_COUNT-1:0]  o_held
);

    localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);
    localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LONG    = 2'd2
    } state_t;

`ifndef BUTTON_EVENT_AUTO_REPEAT_EN
    logic unused_repeat_count;
    assign unused_repeat_count = ^i_repeat_count;
`endif

    for (genvar gi = 0; gi < int'(BUTTON_COUNT); gi++) begin : g_chan
        state_t                   state, state_nxt;
        logic [COUNTER_WIDTH-1:0] hold, hold_nxt, hold_inc;
        logic                     press_q, press_nxt;
        logic                     release_q, release_nxt;
        logic                     long_q, long_nxt;
        logic                     held_q;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
        logic [COUNTER_WIDTH-1:0] rep, rep_nxt;
        logic                     repeat_q, repeat_nxt;
`endif

        // Hold count including the current sample, saturating at all-ones.
        assign hold_inc = (hold == CNT_MAX) ? hold : hold + CNT_ONE;

        always_comb begin
            state_nxt   = state;
            hold_nxt    = hold;
            press_nxt   = 1'b0;
            release_nxt = 1'b0;
            long_nxt    = 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
            rep_nxt     = rep;
            repeat_nxt  = 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (i_buttons[gi]) begin
                        state_nxt = ST_PRESSED;
                        hold_nxt  = CNT_ONE;
                        press_nxt = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!i_buttons[gi]) begin
                        state_nxt   = ST_IDLE;
                        hold_nxt    = '0;
                        release_nxt = 1'b1;
                    end else begin
                        hold_nxt = hold_inc;
                        if ((i_long_press_count != '0) && (hold_inc >= i_long_press_count)) begin
                            state_nxt = ST_LONG;
                            long_nxt  = 1'b1;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
                            rep_nxt   = CNT_ONE;
`endif
                        end
                    end
                end
                ST_LONG: begin
                    if (!i_buttons[gi]) begin
                        state_nxt   = ST_IDLE;
                        hold_nxt    = '0;
                        release_nxt = 1'b1;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
                        rep_nxt     = '0;
                    end else if (i_repeat_count != '0) begin
                        // rep counts cycles since the last long/repeat pulse.
                        if (rep >= i_repeat_count) begin
                            rep_nxt    = CNT_ONE;
                            repeat_nxt = 1'b1;
                        end else begin
                            rep_nxt = rep + CNT_ONE;
                        end
`endif
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    hold_nxt  = '0;
                end
            endcase
        end

        always_ff @(posedge i_clock or negedge i_reset_n) begin
            if (!i_reset_n) begin
                state     <= ST_IDLE;
                hold      <= '0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
                long_q    <= 1'b0;
                held_q    <= 1'b0;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
                rep       <= '0;
                repeat_q  <= 1'b0;
`endif
            end else begin
                state     <= state_nxt;
                hold      <= hold_nxt;
                press_q   <= press_nxt;
                release_q <= release_nxt;
                long_q    <= long_nxt;
                held_q    <= (state_nxt != ST_IDLE);
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
                rep       <= rep_nxt;
                repeat_q  <= repeat_nxt;
`endif
            end
        end

        assign o_press_pulse[gi]      = press_q;
        assign o_release_pulse[gi]    = release_q;
        assign o_long_press_pulse[gi] = long_q;
        assign o_held[gi]             = held_q;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
        assign o_repeat_pulse[gi]     = repeat_q;
`else
        assign o_repeat_pulse[gi]     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Scoreboard bench for button_event_decoder: a run-length reference model predicts every
// output vector; a monitor compares one queued prediction after each rising edge.
module tb_button_event_decoder;

    localparam int unsigned N  = 5;
    localparam int unsigned CW = 24;
`ifdef BUTTON_EVENT_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [N-1:0]  btn;
    logic [CW-1:0] lp, rp;
    logic [N-1:0]  press, rel, lng, rep, held;

    button_event_decoder #(.BUTTON_COUNT(N), .COUNTER_WIDTH(CW)) dut (
        .i_clock            (clk),
        .i_reset_n          (rst_n),
        .i_buttons          (btn),
        .i_long_press_count (lp),
        .i_repeat_count     (rp),
        .o_press_pulse      (press),
        .o_release_pulse    (rel),
        .o_long_press_pulse (lng),
        .o_repeat_pulse     (rep),
        .o_held             (held)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] press, rel, lng, rep, held;
    } exp_t;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    // Model state: consecutive high samples, whether long fired, sample index of last long/repeat.
    int run_len[N];
    bit is_long[N];
    int last_ev[N];

    function automatic void model_reset();
        for (int i = 0; i < int'(N); i++) begin
            run_len[i] = 0;
            is_long[i] = 1'b0;
            last_ev[i] = 0;
        end
    endfunction

    function automatic exp_t model_step(logic [N-1:0] b, int l_thr, int r_thr);
        exp_t e;
        e = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (b[i]) begin
                run_len[i]++;
                e.held[i] = 1'b1;
                if (run_len[i] == 1) begin
                    e.press[i] = 1'b1;
                end else if (!is_long[i] && l_thr != 0 && run_len[i] >= l_thr) begin
                    e.lng[i]   = 1'b1;
                    is_long[i] = 1'b1;
                    last_ev[i] = run_len[i];
                end else if (is_long[i] && REP_EN && r_thr != 0 && run_len[i] - last_ev[i] >= r_thr) begin
                    e.rep[i]   = 1'b1;
                    last_ev[i] = run_len[i];
                end
            end else begin
                if (run_len[i] > 0) e.rel[i] = 1'b1;
                run_len[i] = 0;
                is_long[i] = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic chk(string nm, logic [N-1:0] act, logic [N-1:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp_v);
        end
    endtask

    // Apply inputs now (called at a falling edge) and queue the prediction for the next rising edge.
    task automatic apply(logic [N-1:0] b, int l_thr, int r_thr);
        btn = b;
        lp  = CW'(l_thr);
        rp  = CW'(r_thr);
        q.push_back(model_step(b, l_thr, r_thr));
    endtask

    task automatic drive(logic [N-1:0] b, int l_thr, int r_thr);
        @(negedge clk);
        apply(b, l_thr, r_thr);
    endtask

    task automatic hold_for(logic [N-1:0] b, int cycles, int l_thr, int r_thr);
        for (int k = 0; k < cycles; k++) drive(b, l_thr, r_thr);
    endtask

    task automatic chk_all_zero(string nm);
        chk({nm, "_press"}, press, '0);
        chk({nm, "_rel"},   rel,   '0);
        chk({nm, "_long"},  lng,   '0);
        chk({nm, "_rep"},   rep,   '0);
        chk({nm, "_held"},  held,  '0);
    endtask

    // Monitor: compare one prediction per rising edge whenever one is pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("press",   press, e.press);
                chk("release", rel,   e.rel);
                chk("long",    lng,   e.lng);
                chk("repeat",  rep,   e.rep);
                chk("held",    held,  e.held);
            end
        end
    end

    initial begin
        logic [N-1:0] b;
        int           l_thr, r_thr;
        model_reset();
        rst_n = 1'b0;
        btn   = '0;
        lp    = '0;
        rp    = '0;
        #1;
        chk_all_zero("reset");
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_hold");

        // Release reset with all idle, then the basic short press on btn0.
        @(negedge clk);
        rst_n = 1'b1;
        apply('0, 10, 4);
        hold_for(5'b00001, 5, 10, 4);
        hold_for(5'b00000, 3, 10, 4);

        // Long press then repeats on btn2.
        hold_for(5'b00100, 30, 10, 4);
        hold_for(5'b00000, 3, 10, 4);

        // Long-press disabled: btn1 held 100 cycles.
        hold_for(5'b00010, 100, 0, 4);
        hold_for(5'b00000, 2, 0, 4);

        // btn3 released one sample short of the threshold, then exactly at it.
        hold_for(5'b01000, 7, 8, 4);
        hold_for(5'b00000, 2, 8, 4);
        hold_for(5'b01000, 8, 8, 4);
        hold_for(5'b00000, 2, 8, 4);

        // All pressed together, staggered releases.
        hold_for(5'b11111, 3, 6, 2);
        hold_for(5'b11110, 2, 6, 2);
        hold_for(5'b11100, 3, 6, 2);
        hold_for(5'b11000, 4, 6, 2);
        hold_for(5'b10000, 5, 6, 2);
        hold_for(5'b00000, 2, 6, 2);

        // Threshold lowered live below the current hold count.
        hold_for(5'b00001, 20, 50, 3);
        hold_for(5'b00001, 10, 5, 3);
        hold_for(5'b00000, 2, 5, 3);

        // Reset mid-hold: outputs clear at once; button still high gives a fresh press.
        hold_for(5'b10001, 6, 4, 2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        model_reset();
        @(negedge clk);
        #1;
        chk_all_zero("mid_reset_hold");
        rst_n = 1'b1;
        apply(5'b10001, 4, 2);
        hold_for(5'b10001, 8, 4, 2);
        hold_for(5'b00000, 2, 4, 2);

        // Randomized blocks; repeat threshold changes only while everything is idle.
        for (int blk = 0; blk < 8; blk++) begin
            l_thr = int'($urandom_range(0, 12));
            r_thr = int'($urandom_range(0, 5));
            b     = '0;
            for (int c = 0; c < 250; c++) begin
                for (int i = 0; i < int'(N); i++)
                    if ($urandom_range(0, 5) == 0) b[i] = ~b[i];
                if ($urandom_range(0, 39) == 0) l_thr = int'($urandom_range(0, 15));
                drive(b, l_thr, r_thr);
            end
            hold_for('0, 2, l_thr, r_thr);
        end

        repeat (3) @(posedge clk);
        #2;
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d predictions left unchecked, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
